// File: rtl/morse_tx.sv
// Morse-code transmitter: a small character FIFO feeds an FSM that expands
// each queued code (A-Z or word space) into timed marks and spaces on a
// single keying line.
module morse_tx #(
    parameter int UNIT_CYCLES = 25000000,
    parameter int DEPTH       = 4,
    parameter int DASH_UNITS  = 3,
    parameter int LGAP_UNITS  = 3,
    parameter int WGAP_UNITS  = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [4:0]               in_char,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     morse_out,
    output logic                     busy,
    output logic                     char_done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(UNIT_CYCLES * 7);

    // Counter reload values: a state lasting N units holds N*UNIT_CYCLES cycles.
    localparam logic [CNT_W-1:0] LD_DOT  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_DASH = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_LGAP = CNT_W'(LGAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_WGAP = CNT_W'(WGAP_UNITS * UNIT_CYCLES - 1);

    localparam logic [4:0] CODE_SPACE = 5'd26;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_SPACE,
        S_LGAP,
        S_WGAP
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [4:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr_reg;
    logic [PTR_W-1:0] r_rd_ptr_reg;
    logic [PTR_W:0]   r_level_reg;
    logic             r_err_reg;

    logic             w_xfer;
    logic             w_bad;
    logic             w_push;
    logic             w_pop;
    logic [4:0]       w_head;

    // Full blocks pushes outright, even when a pop happens in the same cycle.
    assign in_ready = (r_level_reg != (PTR_W + 1)'(DEPTH));
    assign w_xfer   = in_valid & in_ready;
    assign w_bad    = (in_char > CODE_SPACE);
    assign w_push   = w_xfer & ~w_bad;
    assign w_head   = r_mem[r_rd_ptr_reg];

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_mem[r_wr_ptr_reg] <= in_char;
        end
    end

    // FIFO pointers, occupancy and the invalid-code error pulse.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_wr_ptr_reg <= '0;
            r_rd_ptr_reg <= '0;
            r_level_reg  <= '0;
            r_err_reg    <= 1'b0;
        end else begin
            r_err_reg <= w_xfer & w_bad;
            if (w_push) begin
                r_wr_ptr_reg <= r_wr_ptr_reg + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr_reg <= r_rd_ptr_reg + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level_reg <= r_level_reg + 1'b1;
                2'b01:   r_level_reg <= r_level_reg - 1'b1;
                default: r_level_reg <= r_level_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Symbol ROM: pattern left-aligned, first symbol in bit 3, dash = 1
    // ------------------------------------------------------------------
    logic [3:0] w_rom_pat;
    logic [2:0] w_rom_len;

    // Morse lookup for the FIFO head.
    always_comb begin
        w_rom_pat = 4'b0000;
        w_rom_len = 3'd1;
        case (w_head)
            5'd0:    begin w_rom_pat = 4'b0100; w_rom_len = 3'd2; end // A .-
            5'd1:    begin w_rom_pat = 4'b1000; w_rom_len = 3'd4; end // B -...
            5'd2:    begin w_rom_pat = 4'b1010; w_rom_len = 3'd4; end // C -.-.
            5'd3:    begin w_rom_pat = 4'b1000; w_rom_len = 3'd3; end // D -..
            5'd4:    begin w_rom_pat = 4'b0000; w_rom_len = 3'd1; end // E .
            5'd5:    begin w_rom_pat = 4'b0010; w_rom_len = 3'd4; end // F ..-.
            5'd6:    begin w_rom_pat = 4'b1100; w_rom_len = 3'd3; end // G --.
            5'd7:    begin w_rom_pat = 4'b0000; w_rom_len = 3'd4; end // H ....
            5'd8:    begin w_rom_pat = 4'b0000; w_rom_len = 3'd2; end // I ..
            5'd9:    begin w_rom_pat = 4'b0111; w_rom_len = 3'd4; end // J .---
            5'd10:   begin w_rom_pat = 4'b1010; w_rom_len = 3'd3; end // K -.-
            5'd11:   begin w_rom_pat = 4'b0100; w_rom_len = 3'd4; end // L .-..
            5'd12:   begin w_rom_pat = 4'b1100; w_rom_len = 3'd2; end // M --
            5'd13:   begin w_rom_pat = 4'b1000; w_rom_len = 3'd2; end // N -.
            5'd14:   begin w_rom_pat = 4'b1110; w_rom_len = 3'd3; end // O ---
            5'd15:   begin w_rom_pat = 4'b0110; w_rom_len = 3'd4; end // P .--.
            5'd16:   begin w_rom_pat = 4'b1101; w_rom_len = 3'd4; end // Q --.-
            5'd17:   begin w_rom_pat = 4'b0100; w_rom_len = 3'd3; end // R .-.
            5'd18:   begin w_rom_pat = 4'b0000; w_rom_len = 3'd3; end // S ...
            5'd19:   begin w_rom_pat = 4'b1000; w_rom_len = 3'd1; end // T -
            5'd20:   begin w_rom_pat = 4'b0010; w_rom_len = 3'd3; end // U ..-
            5'd21:   begin w_rom_pat = 4'b0001; w_rom_len = 3'd4; end // V ...-
            5'd22:   begin w_rom_pat = 4'b0110; w_rom_len = 3'd3; end // W .--
            5'd23:   begin w_rom_pat = 4'b1001; w_rom_len = 3'd4; end // X -..-
            5'd24:   begin w_rom_pat = 4'b1011; w_rom_len = 3'd4; end // Y -.--
            5'd25:   begin w_rom_pat = 4'b1100; w_rom_len = 3'd4; end // Z --..
            default: begin w_rom_pat = 4'b0000; w_rom_len = 3'd1; end
        endcase
    end

    // ------------------------------------------------------------------
    // Timing FSM
    // ------------------------------------------------------------------
    state_t           r_state_reg;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt_reg;
    logic [CNT_W-1:0] w_cnt_next;
    logic [3:0]       r_sym_reg;
    logic [3:0]       w_sym_next;
    logic [2:0]       r_left_reg;
    logic [2:0]       w_left_next;
    logic             r_morse_reg;
    logic             w_expired;

    assign w_expired = (r_cnt_reg == '0);

    // State, unit counter, symbol shifter and registered keying output.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state_reg <= S_IDLE;
            r_cnt_reg   <= '0;
            r_sym_reg   <= '0;
            r_left_reg  <= '0;
            r_morse_reg <= 1'b0;
        end else begin
            r_state_reg <= w_state_next;
            r_cnt_reg   <= w_cnt_next;
            r_sym_reg   <= w_sym_next;
            r_left_reg  <= w_left_next;
            r_morse_reg <= (w_state_next == S_MARK);
        end
    end

    // Next-state logic: each state reloads the counter on entry and leaves
    // when it reaches zero; bit 3 of the shifter is always the current symbol.
    always_comb begin
        w_state_next = r_state_reg;
        w_cnt_next   = w_expired ? r_cnt_reg : r_cnt_reg - 1'b1;
        w_sym_next   = r_sym_reg;
        w_left_next  = r_left_reg;
        w_pop        = 1'b0;
        case (r_state_reg)
            S_IDLE: begin
                w_cnt_next = r_cnt_reg;
                if (r_level_reg != '0) begin
                    w_pop = 1'b1;
                    if (w_head == CODE_SPACE) begin
                        w_state_next = S_WGAP;
                        w_cnt_next   = LD_WGAP;
                    end else begin
                        w_state_next = S_MARK;
                        w_sym_next   = w_rom_pat;
                        w_left_next  = w_rom_len;
                        w_cnt_next   = w_rom_pat[3] ? LD_DASH : LD_DOT;
                    end
                end
            end
            S_MARK: begin
                if (w_expired) begin
                    if (r_left_reg > 3'd1) begin
                        w_state_next = S_SPACE;
                        w_cnt_next   = LD_DOT;
                        w_sym_next   = {r_sym_reg[2:0], 1'b0};
                        w_left_next  = r_left_reg - 3'd1;
                    end else begin
                        w_state_next = S_LGAP;
                        w_cnt_next   = LD_LGAP;
                    end
                end
            end
            S_SPACE: begin
                if (w_expired) begin
                    w_state_next = S_MARK;
                    w_cnt_next   = r_sym_reg[3] ? LD_DASH : LD_DOT;
                end
            end
            S_LGAP, S_WGAP: begin
                if (w_expired) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign morse_out  = r_morse_reg;
    assign err        = r_err_reg;
    assign fifo_level = r_level_reg;
    assign busy       = (r_state_reg != S_IDLE) || (r_level_reg != '0);
    assign char_done  = ((r_state_reg == S_LGAP) || (r_state_reg == S_WGAP)) && w_expired;

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx with UNIT_CYCLES=4: keying waveforms are
// captured as run lengths and compared against hand-computed patterns.
module tb_morse_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] in_char = 5'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       morse_out;
    logic       busy;
    logic       char_done;
    logic       err;
    logic [2:0] fifo_level;

    int n_vec  = 0;
    int n_miss = 0;

    int   runs[$];
    int   cd_idx[$];
    int   err_cnt;
    int   first_lvl;
    int   last_busy;

    int exp_e[$]  = '{1, 4, 13};
    int exp_a[$]  = '{1, 4, 4, 12, 13};
    int exp_sq[$] = '{1, 4, 4, 4, 4, 4, 13, 12, 4, 12, 4, 12, 30, 12, 13,
                      4, 13, 12, 4, 12, 4, 4, 4, 12, 14};
    int exp_q0[$] = '{20};

    morse_tx #(
        .UNIT_CYCLES (4),
        .DEPTH       (4)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .in_char    (in_char),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .morse_out  (morse_out),
        .busy       (busy),
        .char_done  (char_done),
        .err        (err),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sample n cycles at negedges; first sample is the cycle after the caller's edge.
    task automatic record(input int n);
        int prev;
        int len;
        runs.delete();
        cd_idx.delete();
        err_cnt = 0;
        prev = 0;
        len = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                prev = int'(morse_out);
                first_lvl = prev;
                len = 1;
            end else if (int'(morse_out) == prev) begin
                len++;
            end else begin
                runs.push_back(len);
                prev = int'(morse_out);
                len = 1;
            end
            if (char_done) cd_idx.push_back(i);
            if (err) err_cnt++;
            last_busy = int'(busy);
        end
        runs.push_back(len);
    endtask

    task automatic cmp_runs(input string tag, input int exp[$]);
        chk({tag, "_first_lvl"}, first_lvl, 0);
        chk({tag, "_nruns"}, runs.size(), exp.size());
        for (int i = 0; i < exp.size() && i < runs.size(); i++) begin
            chk($sformatf("%s_run%0d", tag, i), runs[i], exp[i]);
        end
    endtask

    task automatic push1(input int code);
        @(negedge clk);
        in_char  = 5'(code);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("push code %0d accepted=%0d", code, 1);
    endtask

    // Back-to-back pushes with in_valid held; starts at a negedge with
    // the first code already driven.
    task automatic push_seq(input int seq[$]);
        int i;
        int t;
        int stall;
        logic acc;
        i = 0;
        t = 0;
        stall = 0;
        while (i < seq.size() && t < 300) begin
            acc = in_ready;
            if (!acc && i == 5) stall++;
            @(posedge clk);
            #1;
            if (acc) begin
                $display("push code %0d at cycle %0d", seq[i], t);
                i++;
                if (i == 5) begin
                    chk("full_level", int'(fifo_level), 4);
                    chk("full_ready", int'(in_ready), 0);
                end
                if (i < seq.size()) in_char = 5'(seq[i]);
                else in_valid = 1'b0;
            end
            t++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("seq_pushed", i, seq.size());
        chk("seq_stall", stall, 30);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        n_miss++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int seq[$];

        // 1: reset for 3 cycles, then idle and stable
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_morse", int'(morse_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_done", int'(char_done), 0);
        chk("rst_err", int'(err), 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (morse_out || busy || !in_ready || fifo_level != 3'd0 || char_done || err) bad++;
        end
        chk("idle_stable", bad, 0);
        $display("reset phase done");

        // 2: E
        push1(4);
        record(18);
        cmp_runs("e", exp_e);
        chk("e_ndone", cd_idx.size(), 1);
        chk("e_done_at", cd_idx.size() > 0 ? cd_idx[0] : -1, 16);
        chk("e_busy_end", last_busy, 0);

        // 3: A
        push1(0);
        record(34);
        cmp_runs("a", exp_a);
        chk("a_ndone", cd_idx.size(), 1);
        chk("a_done_at", cd_idx.size() > 0 ? cd_idx[0] : -1, 32);
        chk("a_busy_end", last_busy, 0);

        // 4: invalid code
        push1(29);
        @(negedge clk);
        chk("inv_err", int'(err), 1);
        chk("inv_level", int'(fifo_level), 0);
        chk("inv_morse", int'(morse_out), 0);
        chk("inv_busy", int'(busy), 0);
        @(negedge clk);
        chk("inv_err_clr", int'(err), 0);
        chk("inv_busy2", int'(busy), 0);

        // 5: S O space T E Q back-to-back
        seq = '{18, 14, 26, 19, 4, 16};
        @(negedge clk);
        in_char  = 5'd18;
        in_valid = 1'b1;
        fork
            push_seq(seq);
            begin
                @(posedge clk);
                record(216);
            end
        join
        cmp_runs("seq", exp_sq);
        chk("seq_ndone", cd_idx.size(), 6);
        chk("seq_done0", cd_idx.size() > 0 ? cd_idx[0] : -1, 32);
        chk("seq_done5", cd_idx.size() > 5 ? cd_idx[5] : -1, 213);
        chk("seq_err", err_cnt, 0);
        chk("seq_busy_end", last_busy, 0);

        // 6: reset in the middle of T's dash
        push1(19);
        for (int i = 0; i < 7; i++) @(negedge clk);
        chk("t_mid_mark", int'(morse_out), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t_rst_morse", int'(morse_out), 0);
        chk("t_rst_level", int'(fifo_level), 0);
        chk("t_rst_busy", int'(busy), 0);
        chk("t_rst_done", int'(char_done), 0);
        reset = 1'b0;
        record(20);
        cmp_runs("t_quiet", exp_q0);
        chk("t_quiet_ndone", cd_idx.size(), 0);
        chk("t_quiet_busy", last_busy, 0);
        push1(4);
        record(18);
        cmp_runs("e2", exp_e);
        chk("e2_ndone", cd_idx.size(), 1);
        chk("e2_done_at", cd_idx.size() > 0 ? cd_idx[0] : -1, 16);
        chk("e2_busy_end", last_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/morse_tx.md
Name: morse_tx

Overview:
- Parametrised Morse-code transmitter: queued, full A–Z alphabet with word spaces and configurable timing, driving a single LED/keying line.
- Characters arrive over a valid/ready interface into a small FIFO.
- An FSM expands each character from an internal ROM into timed marks and spaces.
- Sits between switch/key input logic and a board LED; replaces fixed 8-letter, fixed-slot signalling.

Parameters:
- UNIT_CYCLES, 25000000: clock cycles per Morse time unit; 0.5 s at 50 MHz.
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- DASH_UNITS, 3: mark length of a dash, in units.
- LGAP_UNITS, 3: off time after the last symbol of a letter.
- WGAP_UNITS, 4: extra off time for a space character. LGAP_UNITS + WGAP_UNITS = 7 total.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- in_char  in  5  character code: 0–25 = A–Z, 26 = word space, 27–31 invalid.
- in_valid  in  1  in_char valid.
- in_ready  out  1  FIFO can accept.
- morse_out  out  1  keying output; 1 = mark (LED on).
- busy  out  1  FSM not IDLE, or FIFO non-empty.
- char_done  out  1  one-cycle pulse at the end of each character's trailing gap.
- err  out  1  one-cycle pulse when an invalid code is offered.
- fifo_level  out  $clog2(DEPTH)+1  entries currently queued.

Behaviour:

Reset:
- Any rising CLOCK_50 edge with reset=1 flushes the FIFO and forces IDLE.
- Next-cycle values: morse_out=0, char_done=0, err=0, fifo_level=0, busy=0, in_ready=1.
- Reset mid-mark aborts the character; no char_done is generated.

Input handshake:
- A transfer occurs when in_valid & in_ready on a rising edge.
- in_ready = (fifo_level != DEPTH). A push is blocked while full, even if a pop happens in the same cycle.
- A transferred code of 27–31 is not stored; err pulses on the following cycle.
- Push and pop in the same cycle leave fifo_level unchanged.

ROM:
- Standard international Morse. Length 1–4 symbols; dot=0, dash=1; first symbol sent first.
- Examples: A=.-, E=., O=---, Q=--.-, S=..., T=-, Z=--..

Unit timing:
- A single down-counter (width $clog2(UNIT_CYCLES*7)) is loaded with N*UNIT_CYCLES-1 on each state entry.
- A state lasting N units therefore lasts exactly N*UNIT_CYCLES cycles.

FSM states:
- IDLE: morse_out=0. If the FIFO is non-empty, pop the head and load the symbol shift register and count.
  - Letter: go to MARK next cycle.
  - Code 26: go to WGAP.
- MARK: morse_out=1 for 1 unit (dot) or DASH_UNITS units (dash).
  - On expiry: go to SPACE if symbols remain, else LGAP.
- SPACE: morse_out=0 for 1 unit, then MARK with the next symbol.
- LGAP: morse_out=0 for LGAP_UNITS units. char_done=1 on the last cycle, then IDLE.
- WGAP: morse_out=0 for WGAP_UNITS units. char_done=1 on the last cycle, then IDLE.

Pipeline timing:
- Exactly one IDLE cycle separates consecutive characters. Within a letter, the first mark begins the cycle after the pop.
- morse_out is registered. It changes on the edge at which the FSM enters or leaves MARK.

Test Plan (UNIT_CYCLES=4, DEPTH=4, defaults otherwise):
1. Reset held 3 cycles, then released → morse_out=0, busy=0, in_ready=1, fifo_level=0; all stay stable with no input.
2. Push E (4) → morse_out high exactly 4 cycles, then low 12 cycles. char_done pulses on the 12th low cycle; busy=0 the cycle after.
3. Push A (0) → morse_out pattern high 4, low 4, high 12, low 12; exactly one char_done.
4. Push 29 → err=1 for one cycle, fifo_level stays 0, morse_out stays 0, busy stays 0.
5. Sequence of pushes with in_valid held:
   - Push S, O, 26, T, E, Q back-to-back.
   - in_ready drops when fifo_level=4 and holds further pushes until a pop.
   - Output order: S,O,space,T,E,Q.
   - O→T off time = 12+1+16+1 = 30 cycles.
   - Six char_done pulses in total.
6. Push T, then assert reset during its dash mark (cycle 6 of 12) → next cycle morse_out=0, fifo_level=0, busy=0, no char_done. A new push of E then transmits normally.
